mem_access_unit: RTL and testbench

Load/store sequencer between the pipeline MEM stage and the byte-enabled data memory (`dmem`). It accepts one RISC-V load/store request at a time and drives the `dmem_*` port. Each store is issued only as `dmem`-legal lane patterns, and misaligned accesses are split into multiple memory beats. Load data is returned size-extracted and sign- or zero-extended. The pipeline stalls on `req_ready` low and consumes `resp_valid`.

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 86 ++++++++
 tb/tb_mem_access_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and dmem port bundle for the load/store sequencer.
interface mem_access_unit_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            dmem_we;
  logic [3:0]      dmem_amp;
  logic [XLEN-1:0] dmem_a;
  logic [XLEN-1:0] dmem_wd;
  logic [XLEN-1:0] dmem_rd;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, dmem_we, dmem_amp, dmem_a, dmem_wd
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, dmem_we, dmem_amp, dmem_a, dmem_wd
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time RISC-V load/store sequencer splitting misaligned accesses into legal dmem beats.
module mem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rstn,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LD0, LD1, ST, RESP} state_t;
  state_t state, nxt;
  logic [XLEN-1:0] addr, wdata, buf0, buf1, rdata, b, win, ext;
  logic [2:0] f3;
  logic [1:0] k, last;
  logic [7:0] wbyte;
  logic err, req_bad, hs, mis, sx;
  assign req_bad = bus.req_we ? (bus.req_funct3[2] | bus.req_funct3 == 3'b011)
                              : (bus.req_funct3 == 3'b011 | bus.req_funct3[2:1] == 2'b11);
  assign hs    = bus.req_valid & bus.req_ready;
  assign mis   = (f3[1:0] == 2'b01 & addr[0]) | (f3[1:0] == 2'b10 & addr[1:0] != 2'b00);
  assign last  = f3[1:0] == 2'b01 ? 2'd1 : 2'd3;
  assign b     = addr + {30'b0, k};
  assign wbyte = 8'(wdata >> {k, 3'b000});
  // In LD0 the live read is the low word; in LD1 it is the high word.
  assign win   = 32'((state == LD1 ? {bus.dmem_rd, buf0} : {buf1, bus.dmem_rd}) >> {addr[1:0], 3'b000});
  assign sx    = ~f3[2];
  assign ext   = f3[1:0] == 2'b00 ? {{24{sx & win[7]}}, win[7:0]}
               : f3[1:0] == 2'b01 ? {{16{sx & win[15]}}, win[15:0]} : win;
  always_ff @(posedge clk)
    state <= !rstn ? IDLE : nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = !bus.req_valid ? IDLE : req_bad ? RESP : bus.req_we ? ST : LD0;
      LD0:     nxt = mis ? LD1 : RESP;
      LD1:     nxt = RESP;
      ST:      nxt = (!mis || k == last) ? RESP : ST;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Reset gates dmem outputs immediately so an aborted store commits no further beat.
  always_comb begin
    bus.req_ready  = state == IDLE;
    bus.resp_valid = state == RESP;
    bus.resp_rdata = rdata;
    bus.resp_err   = err;
    bus.dmem_we    = 1'b0;
    bus.dmem_amp   = 4'b0000;
    bus.dmem_a     = '0;
    bus.dmem_wd    = '0;
    if (rstn)
      unique case (state)
        LD0: bus.dmem_a = {addr[31:2], 2'b00};
        LD1: bus.dmem_a = {addr[31:2] + 30'd1, 2'b00};
        ST: begin
          bus.dmem_we  = 1'b1;
          bus.dmem_a   = mis ? {b[31:2], 2'b00} : {addr[31:2], 2'b00};
          bus.dmem_amp = mis ? 4'b0001 << b[1:0]
                       : f3[1:0] == 2'b10 ? 4'b1111
                       : f3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011)
                       : 4'b0001 << addr[1:0];
          bus.dmem_wd  = mis ? {24'b0, wbyte} : wdata;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      k     <= 2'd0;
      buf0  <= '0;
      buf1  <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      if (hs) begin
        addr <= bus.req_addr;
        f3   <= bus.req_funct3;
        if (bus.req_we) wdata <= bus.req_wdata;
      end
      k <= (state == ST && nxt == ST) ? k + 2'd1 : 2'd0;
      if (state == LD0) buf0 <= bus.dmem_rd;
      if (state == LD1) buf1 <= bus.dmem_rd;
      rdata <= ((state == LD0 || state == LD1) && nxt == RESP) ? ext : '0;
      err   <= hs & req_bad;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic init = 1'b1;
  always #5 clk = ~clk;
  mem_access_unit_if bus();
  mem_access_unit dut (.clk(clk), .rstn(rstn), .bus(bus));
  typedef struct packed {logic [31:0] a; logic [3:0] amp; logic [31:0] wd;} beat_t;
  logic [7:0] mem [256];
  logic [7:0] refm [256];
  beat_t beats[$];
  int writes = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] base;
  assign base = bus.dmem_a[7:0];
  always_comb bus.dmem_rd = {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.dmem_we) begin
      beats.push_back({bus.dmem_a, bus.dmem_amp, bus.dmem_wd});
      writes <= writes + 1;
      for (int l = 0; l < 4; l++)
        if (bus.dmem_amp[l])
          mem[{bus.dmem_a[7:2], 2'(l)}] <= bus.dmem_amp == 4'hf ? bus.dmem_wd[8*l +: 8]
            : (bus.dmem_amp == 4'h3 || bus.dmem_amp == 4'hc) ? bus.dmem_wd[8*(l%2) +: 8]
            : bus.dmem_wd[7:0];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rstn && !init) begin
      check("amp_legal", 32'(bus.dmem_amp inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hc, 4'hf}), 1);
      check("a_align", 32'(bus.dmem_a[1:0]), 0);
      if (!bus.resp_valid) check("rdata_quiet", {bus.resp_rdata[31:1], bus.resp_err}, 0);
    end
  function automatic int size_of(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction
  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) d++;
    return d;
  endfunction
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rd);
    int n = size_of(f3);
    logic bad = we ? (f3[2] || f3 == 3'b011) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    logic unal = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    int lat = bad ? 1 : !unal ? 2 : we ? 1 + n : 3;
    int w0, cyc, guard;
    logic got;
    logic [31:0] exp = 32'h0;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    check("ready_wait", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    w0 = writes;
    beats.delete();
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    cyc = 0;
    got = 1'b0;
    while (cyc < 12 && !got) begin
      @(negedge clk);
      cyc++;
      got = bus.resp_valid;
    end
    check("latency", got ? cyc : 0, lat);
    check("err", 32'(bus.resp_err), 32'(bad));
    if (!we && !bad) begin
      for (int i = 0; i < n; i++) exp |= 32'(refm[8'(addr + 32'(i))]) << (8 * i);
      if (!f3[2] && n < 4 && exp[8*n-1]) exp |= 32'hFFFFFFFF << (8 * n);
    end
    check("rdata", bus.resp_rdata, exp);
    rd = bus.resp_rdata;
    if (we && !bad)
      for (int i = 0; i < n; i++) refm[8'(addr + 32'(i))] = wd[8*i +: 8];
    @(negedge clk);
    check("resp_pulse", {30'b0, bus.resp_valid, bus.req_ready}, 32'b01);
    check("writes", writes - w0, (we && !bad) ? (unal ? n : 1) : 0);
    if (we) check("mem_image", mem_diff(), 0);
  endtask
  logic [31:0] rd;
  logic seen;
  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) refm[i] = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    @(posedge clk);
    #1 init = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_resp", {bus.resp_rdata[31:2], bus.resp_valid, bus.resp_err}, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_dmem", {27'b0, bus.dmem_we, bus.dmem_amp}, 0);
    check("rst_dmem_a", bus.dmem_a | bus.dmem_wd, 0);
    rstn = 1'b1;
    run(1'b1, 3'b010, 32'h100, 32'h11223344, rd);
    check("sw_beats", beats.size(), 1);
    check("sw_beat_a", beats[0].a, 32'h100);
    check("sw_beat_amp", 32'(beats[0].amp), 32'hf);
    run(1'b0, 3'b010, 32'h100, 32'h0, rd);
    check("lw_100", rd, 32'h11223344);
    run(1'b1, 3'b010, 32'h100, 32'h8A223344, rd);
    run(1'b0, 3'b000, 32'h103, 32'h0, rd);
    check("lb_103", rd, 32'hFFFFFF8A);
    run(1'b0, 3'b100, 32'h103, 32'h0, rd);
    check("lbu_103", rd, 32'h0000008A);
    run(1'b0, 3'b001, 32'h100, 32'h0, rd);
    check("lh_100", rd, 32'h00003344);
    run(1'b1, 3'b001, 32'h103, 32'h0000BEEF, rd);
    check("sh_beats", beats.size(), 2);
    check("sh_beat0", {beats[0].a[27:0], beats[0].amp}, {28'h100, 4'b1000});
    check("sh_wd0", beats[0].wd, 32'hEF);
    check("sh_beat1", {beats[1].a[27:0], beats[1].amp}, {28'h104, 4'b0001});
    check("sh_wd1", beats[1].wd, 32'hBE);
    run(1'b0, 3'b101, 32'h103, 32'h0, rd);
    check("lhu_103", rd, 32'h0000BEEF);
    run(1'b1, 3'b010, 32'h101, 32'hA1B2C3D4, rd);
    check("swm_beats", beats.size(), 4);
    check("swm_amps", {16'b0, beats[0].amp, beats[1].amp, beats[2].amp, beats[3].amp}, 32'h2481);
    check("swm_a2", beats[2].a, 32'h100);
    check("swm_a3", beats[3].a, 32'h104);
    run(1'b0, 3'b010, 32'h101, 32'h0, rd);
    check("lw_101", rd, 32'hA1B2C3D4);
    run(1'b1, 3'b010, 32'hFFFFFFFE, 32'h55667788, rd);
    check("wrap_a", beats[2].a, 32'h0);
    run(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, rd);
    check("lw_wrap", rd, 32'h55667788);
    run(1'b0, 3'b011, 32'h100, 32'h0, rd);
    run(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, rd);
    run(1'b1, 3'b010, 32'h100, 32'h0, rd);
    run(1'b1, 3'b010, 32'h104, 32'h99999999, rd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h101;
    bus.req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.req_ready), 1);
    check("abort_we", 32'(bus.dmem_we), 0);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= bus.resp_valid; end
    check("abort_no_resp", 32'(seen), 0);
    check("abort_mem", {mem[8'h01], mem[8'h02], mem[8'h03], mem[8'h04]}, 32'hD4C30099);
    refm[8'h01] = 8'hD4;
    refm[8'h02] = 8'hC3;
    check("abort_image", mem_diff(), 0);
    run(1'b0, 3'b010, 32'h101, 32'h0, rd);
    for (int t = 0; t < 300; t++)
      run(1'($urandom), 3'($urandom), $urandom, $urandom, rd);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
